// File: rtl/fixed_p_pkg.sv
// Shared types and elaboration helpers for the fixed-point arithmetic blocks.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fixed_p_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

    function automatic bit widths_consistent(input int width, input int int_width,
                                             input int fract_width);
        return (int_width + fract_width) == width;
    endfunction

endpackage

// File: rtl/fixed_p_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, consumed only while the divider is busy.
module fixed_p_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;

    // The subtraction is safe at WIDTH+1 bits: when taken, the true result is below divisor.
    always_comb begin
        shifted  = {rem, msb};
        q_bit    = (shifted >= {2'b00, divisor});
        next_rem = q_bit ? (shifted[WIDTH:0] - {1'b0, divisor}) : shifted[WIDTH:0];
    end

endmodule

// File: rtl/fixed_p_std_div_pipe.sv
// Unsigned fixed-point divider: floor((left << FRACT_WIDTH) / right), one bit per cycle.
// Latency: done pulses N+1 cycles after go is sampled (1 cycle on divide by zero), N = WIDTH+FRACT_WIDTH.
// Backpressure: go/done handshake; operands are latched, go is ignored while busy.
module fixed_p_std_div_pipe
    import fixed_p_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             overflow,
    output logic             done
);

    localparam int N  = WIDTH + FRACT_WIDTH;
    localparam int CW = $clog2(N + 1);

    if (!widths_consistent(WIDTH, INT_WIDTH, FRACT_WIDTH)) begin : g_width_check
        $error("fixed_p_std_div_pipe: INT_WIDTH + FRACT_WIDTH must equal WIDTH");
    end

    div_state_t       state;
    logic [N-1:0]     dividend;
    logic [N-1:0]     quotient;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] divisor;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   step_rem;
    logic             step_q;

    fixed_p_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .msb      (dividend[N-1]),
        .divisor  (divisor),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            done          <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
            overflow      <= 1'b0;
            dividend      <= '0;
            quotient      <= '0;
            rem           <= '0;
            divisor       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        if (right != '0) begin
                            dividend <= {left, {FRACT_WIDTH{1'b0}}};
                            divisor  <= right;
                            quotient <= '0;
                            rem      <= '0;
                            cnt      <= CW'(N);
                            state    <= BUSY;
                        end else begin
                            // All-ones quotient makes the DONE state report overflow for free.
                            quotient <= '1;
                            rem      <= '0;
                            cnt      <= '0;
                            state    <= DONE;
                        end
                    end
                end
                BUSY: begin
                    dividend <= dividend << 1;
                    quotient <= {quotient[N-2:0], step_q};
                    rem      <= step_rem;
                    cnt      <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done          <= 1'b1;
                    out_quotient  <= quotient[WIDTH-1:0];
                    out_remainder <= rem[WIDTH-1:0];
                    overflow      <= |quotient[N-1:WIDTH];
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
